// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Purpose:
//   Two requesters share one external combinational ALU. The arbiter accepts
//   one request at a time. It forwards the winner's operands and opcode to the
//   ALU through registers. It captures the ALU result and signals completion
//   back to the requester it served.
//   Every transaction takes exactly three cycles: IDLE -> EXEC -> RESP -> IDLE.
//
// Configuration macro:
//   ALU_ARB_RR_EN  defined   : round-robin. On a tie, the requester that was
//                              not granted last wins.
//                  undefined : fixed priority. Requester 0 always wins a tie,
//                              and no last-grant state is kept.
//
// Parameters:
//   DBIT    operand / result width
//   COD_OP  opcode width
//
// Ports:
//   clk                 single clock, rising edge
//   reset               asynchronous, active-low reset
//   i_req0 / i_req1     level requests; held until the matching ack
//   i_a0,i_b0,i_op0     requester 0 operands and opcode
//   i_a1,i_b1,i_op1     requester 1 operands and opcode
//   o_ack0 / o_ack1     one-cycle pulse: the arbiter has captured the operands
//   o_done0 / o_done1   one-cycle pulse: o_result holds this requester's result
//   o_result            registered ALU result, shared by both requesters
//   o_busy              high whenever the FSM is not in IDLE
//   o_alu_a, o_alu_b    registered operands driven to the shared ALU
//   o_alu_op            registered opcode driven to the shared ALU
//   i_alu_result        combinational result returned by the shared ALU
// -----------------------------------------------------------------------------
module alu_arbiter #(
  parameter int DBIT   = 8,
  parameter int COD_OP = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req0,
  input  logic              i_req1,
  input  logic [DBIT-1:0]   i_a0,
  input  logic [DBIT-1:0]   i_b0,
  input  logic [COD_OP-1:0] i_op0,
  input  logic [DBIT-1:0]   i_a1,
  input  logic [DBIT-1:0]   i_b1,
  input  logic [COD_OP-1:0] i_op1,
  output logic              o_ack0,
  output logic              o_ack1,
  output logic              o_done0,
  output logic              o_done1,
  output logic [DBIT-1:0]   o_result,
  output logic              o_busy,
  output logic [DBIT-1:0]   o_alu_a,
  output logic [DBIT-1:0]   o_alu_b,
  output logic [COD_OP-1:0] o_alu_op,
  input  logic [DBIT-1:0]   i_alu_result
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]        state;
  logic              grant_id;     // requester served by the current transaction
  logic              win_vld;
  logic              win_id;
  logic [DBIT-1:0]   win_a;
  logic [DBIT-1:0]   win_b;
  logic [COD_OP-1:0] win_op;

`ifdef ALU_ARB_RR_EN
  logic              last_grant;   // reset to 1 so requester 0 wins the first tie
`endif

  // Arbitration. It only matters in IDLE, because requests are sampled only there.
  always_comb begin
    win_vld = i_req0 | i_req1;
`ifdef ALU_ARB_RR_EN
    if (i_req0 && i_req1) begin
      win_id = ~last_grant;
    end else begin
      win_id = ~i_req0;
    end
`else
    win_id = ~i_req0;
`endif
    if (win_id) begin
      win_a  = i_a1;
      win_b  = i_b1;
      win_op = i_op1;
    end else begin
      win_a  = i_a0;
      win_b  = i_b0;
      win_op = i_op0;
    end
  end

  // Stage boundary IDLE->EXEC captures the operands.
  // EXEC->RESP captures the ALU result.
  // RESP->IDLE changes only the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      grant_id <= 1'b0;
      o_alu_a  <= '0;
      o_alu_b  <= '0;
      o_alu_op <= '0;
      o_result <= '0;
`ifdef ALU_ARB_RR_EN
      last_grant <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (win_vld) begin
            o_alu_a  <= win_a;
            o_alu_b  <= win_b;
            o_alu_op <= win_op;
            grant_id <= win_id;
`ifdef ALU_ARB_RR_EN
            last_grant <= win_id;
`endif
            state    <= EXEC;
          end
        end
        EXEC: begin
          o_result <= i_alu_result;
          state    <= RESP;
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // EXEC and RESP each last one cycle, so decoding the state gives the
  // one-cycle ack and done pulses. grant_id selects a single requester,
  // so the two acks, and likewise the two dones, are never high together.
  assign o_busy  = (state != IDLE);
  assign o_ack0  = (state == EXEC) && !grant_id;
  assign o_ack1  = (state == EXEC) &&  grant_id;
  assign o_done0 = (state == RESP) && !grant_id;
  assign o_done1 = (state == RESP) &&  grant_id;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

  localparam int DBIT   = 8;
  localparam int COD_OP = 6;
  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              i_req0 = 1'b0, i_req1 = 1'b0;
  logic [DBIT-1:0]   i_a0 = '0, i_b0 = '0, i_a1 = '0, i_b1 = '0;
  logic [COD_OP-1:0] i_op0 = '0, i_op1 = '0;
  logic              o_ack0, o_ack1, o_done0, o_done1, o_busy;
  logic [DBIT-1:0]   o_result, o_alu_a, o_alu_b, i_alu_result;
  logic [COD_OP-1:0] o_alu_op;

  typedef struct {
    logic           id;
    logic [DBIT-1:0] res;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.DBIT(DBIT), .COD_OP(COD_OP)) dut (
    .clk(clk), .reset(reset),
    .i_req0(i_req0), .i_req1(i_req1),
    .i_a0(i_a0), .i_b0(i_b0), .i_op0(i_op0),
    .i_a1(i_a1), .i_b1(i_b1), .i_op1(i_op1),
    .o_ack0(o_ack0), .o_ack1(o_ack1),
    .o_done0(o_done0), .o_done1(o_done1),
    .o_result(o_result), .o_busy(o_busy),
    .o_alu_a(o_alu_a), .o_alu_b(o_alu_b), .o_alu_op(o_alu_op),
    .i_alu_result(i_alu_result)
  );

  // External shared ALU
  always_comb begin
    case (o_alu_op)
      OP_ADD:  i_alu_result = o_alu_a + o_alu_b;
      OP_SUB:  i_alu_result = o_alu_a - o_alu_b;
      OP_AND:  i_alu_result = o_alu_a & o_alu_b;
      default: i_alu_result = o_alu_a ^ o_alu_b;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic push(input logic id, input logic [DBIT-1:0] res);
    exp_t e;
    e.id  = id;
    e.res = res;
    exp_q.push_back(e);
  endtask

  // Monitor: compares each done pulse against the scoreboard
  always @(negedge clk) begin
    if (reset) begin
      if (o_ack0 && o_ack1) chk("ack_exclusive", 32'(o_ack1), 32'd0);
      if (o_done0 && o_done1) chk("done_exclusive", 32'(o_done1), 32'd0);
      if (o_done0 || o_done1) begin
        if (exp_q.size() == 0) begin
          chk("done_unexpected", {31'd0, o_done1}, 32'hdead);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("done_id", {31'd0, o_done1}, {31'd0, e.id});
          chk("done_result", 32'(o_result), 32'(e.res));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit expired, got 0 expected finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    step(); step();
    reset = 1'b1;
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_result", 32'(o_result), 32'd0);
    chk("rst_alu_a", 32'(o_alu_a), 32'd0);
    chk("rst_alu_op", 32'(o_alu_op), 32'd0);
    chk("rst_ack", {30'd0, o_ack0, o_ack1}, 32'd0);

    // Single request from requester 0: 5 + 3 = 8
    i_req0 = 1'b1; i_a0 = 8'h05; i_b0 = 8'h03; i_op0 = OP_ADD;
    push(1'b0, 8'h08);
    step();
    chk("single_ack0", 32'(o_ack0), 32'd1);
    chk("single_ack1", 32'(o_ack1), 32'd0);
    chk("single_busy", 32'(o_busy), 32'd1);
    chk("single_alu_a", 32'(o_alu_a), 32'h05);
    i_req0 = 1'b0;
    step();
    chk("single_ack0_off", 32'(o_ack0), 32'd0);
    chk("single_done0", 32'(o_done0), 32'd1);
    step();
    chk("single_idle", 32'(o_busy), 32'd0);
    // The ALU registers keep their value in IDLE when nothing is granted.
    i_a0 = 8'hAA;
    step();
    chk("idle_hold_a", 32'(o_alu_a), 32'h05);
    chk("idle_hold_op", 32'(o_alu_op), 32'(OP_ADD));

    // Reset again so the tie starts from the reset arbitration history
    reset = 1'b0;
    #1;
    chk("rst2_result", 32'(o_result), 32'd0);
    step();
    reset = 1'b1;
    step();

    // Tie held for four transactions: req0 gives 1+1=2, req1 gives 10-3=7
    i_req0 = 1'b1; i_a0 = 8'h01; i_b0 = 8'h01; i_op0 = OP_ADD;
    i_req1 = 1'b1; i_a1 = 8'h0A; i_b1 = 8'h03; i_op1 = OP_SUB;
`ifdef ALU_ARB_RR_EN
    push(1'b0, 8'h02); push(1'b1, 8'h07); push(1'b0, 8'h02); push(1'b1, 8'h07);
`else
    push(1'b0, 8'h02); push(1'b0, 8'h02); push(1'b0, 8'h02); push(1'b0, 8'h02);
`endif
    step();
    chk("tie_first_ack0", 32'(o_ack0), 32'd1);
    repeat (9) step();
    i_req0 = 1'b0; i_req1 = 1'b0;
    repeat (3) step();
    chk("tie_all_done", 32'(exp_q.size()), 32'd0);

    // req1 arrives while requester 0 is in EXEC: 7+2=9, then 4&4=4
    i_req0 = 1'b1; i_a0 = 8'h07; i_b0 = 8'h02; i_op0 = OP_ADD;
    push(1'b0, 8'h09); push(1'b1, 8'h04);
    step();
    chk("late_ack0", 32'(o_ack0), 32'd1);
    i_req0 = 1'b0;
    i_req1 = 1'b1; i_a1 = 8'h04; i_b1 = 8'h04; i_op1 = OP_AND;
    step();
    step();
    chk("late_idle_ack1", 32'(o_ack1), 32'd0);
    step();
    chk("late_ack1", 32'(o_ack1), 32'd1);
    chk("late_ack0_off", 32'(o_ack0), 32'd0);
    i_req1 = 1'b0;
    step(); step();

    // Reset asserted during EXEC aborts the transaction without a done
    i_req0 = 1'b1; i_a0 = 8'h11; i_b0 = 8'h22; i_op0 = OP_ADD;
    step();
    chk("abort_ack0", 32'(o_ack0), 32'd1);
    reset = 1'b0;
    i_req0 = 1'b0;
    #1;
    chk("abort_busy", 32'(o_busy), 32'd0);
    chk("abort_result", 32'(o_result), 32'd0);
    chk("abort_ack0_off", 32'(o_ack0), 32'd0);
    chk("abort_alu_a", 32'(o_alu_a), 32'd0);
    step(); step();
    reset = 1'b1;
    step();
    // After the abort, a normal transaction: 2 - 3 = 0xFF
    i_req0 = 1'b1; i_a0 = 8'h02; i_b0 = 8'h03; i_op0 = OP_SUB;
    push(1'b0, 8'hFF);
    step();
    chk("post_abort_ack0", 32'(o_ack0), 32'd1);
    i_req0 = 1'b0;
    step(); step();

    // req0 held: the second ack comes exactly 3 cycles after the first
    i_req0 = 1'b1; i_a0 = 8'h09; i_b0 = 8'h01; i_op0 = OP_ADD;
    push(1'b0, 8'h0A); push(1'b0, 8'h0A);
    step();
    chk("b2b_ack_first", 32'(o_ack0), 32'd1);
    step();
    chk("b2b_gap1", 32'(o_ack0), 32'd0);
    step();
    chk("b2b_gap2", 32'(o_ack0), 32'd0);
    step();
    chk("b2b_ack_second", 32'(o_ack0), 32'd1);
    i_req0 = 1'b0;
    repeat (3) step();

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    chk("final_idle", 32'(o_busy), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
